// File: rtl/incoming_response_buffer.sv
// incoming_response_buffer: R-channel beat FIFO with 1-cycle bypass, burst-done pulse and length-overrun flag
module incoming_response_buffer #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [ID_WIDTH-1:0]              s_id,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic [1:0]                       s_resp,
  input  logic                             s_last,
  input  logic [TAG_WIDTH-1:0]             s_tagid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [1:0]                       out_resp,
  output logic                             out_last,
  output logic [TAG_WIDTH-1:0]             out_tagid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             burst_done,
  output logic                             err_len
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = ID_WIDTH + DATA_WIDTH + TAG_WIDTH + 3;
  logic [BW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [8:0] beat_cnt;
  logic [BW-1:0] s_beat, head;
  logic empty, full, can_load, serve_fifo, serve_bypass, push, s_hs, out_hs;
  always_comb begin
    s_beat       = {s_id, s_data, s_resp, s_last, s_tagid};
    head         = mem[rp[AW-1:0]];
    empty        = wp == rp;
    full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    can_load     = ~out_valid | out_ready;
    serve_fifo   = ~empty & can_load;
    serve_bypass = empty & s_valid & can_load;
    s_ready      = rst & (serve_bypass | ~full);
    push         = s_valid & ~serve_bypass & ~full;
    s_hs         = s_valid & s_ready;
    out_hs       = out_valid & out_ready;
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= s_beat;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
    end else begin
      wp         <= wp + (AW+1)'(push);
      rp         <= rp + (AW+1)'(serve_fifo);
      fifo_count <= fifo_count + CW'(push) - CW'(serve_fifo);
    end
  // FIFO head has priority so older beats always leave before a bypassed one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid                                       <= 1'b0;
      {out_id, out_data, out_resp, out_last, out_tagid} <= '0;
    end else if (serve_fifo) begin
      out_valid                                       <= 1'b1;
      {out_id, out_data, out_resp, out_last, out_tagid} <= head;
    end else if (serve_bypass) begin
      out_valid                                       <= 1'b1;
      {out_id, out_data, out_resp, out_last, out_tagid} <= s_beat;
    end else if (out_hs) begin
      out_valid                                       <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat_cnt   <= '0;
      burst_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      burst_done <= out_hs & out_last;
      if (s_hs) beat_cnt <= s_last ? 9'd0 : beat_cnt + 9'd1;
      if (s_hs && !s_last && beat_cnt[8]) err_len <= 1'b1;
    end
endmodule

// File: tb/tb_incoming_response_buffer.sv
// tb_incoming_response_buffer: directed + random stimulus against a queue-based scoreboard model
module tb_incoming_response_buffer;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid = 1'b0, s_ready;
  logic [3:0] s_id = '0, s_tagid = '0;
  logic [63:0] s_data = '0;
  logic [1:0] s_resp = '0;
  logic s_last = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [3:0] out_id, out_tagid;
  logic [63:0] out_data;
  logic [1:0] out_resp;
  logic out_last;
  logic [2:0] fifo_count;
  logic burst_done, err_len;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  tag;
  } beat_t;
  beat_t q[$];
  int checks = 0, passed = 0, cnt_m = 0;
  logic err_m = 1'b0, bd_m = 1'b0, acc = 1'b0;
  incoming_response_buffer #(.ID_WIDTH(4), .DATA_WIDTH(64), .TAG_WIDTH(4), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id), .s_data(s_data),
    .s_resp(s_resp), .s_last(s_last), .s_tagid(s_tagid),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
    .out_resp(out_resp), .out_last(out_last), .out_tagid(out_tagid),
    .fifo_count(fifo_count), .burst_done(burst_done), .err_len(err_len)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Model: every accepted beat is queued; the block holds at most D+1 (output register plus FIFO)
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      q.delete();
      cnt_m = 0;
      err_m = 1'b0;
      bd_m  = 1'b0;
    end
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("fifo_count", 128'(fifo_count), 128'(q.size() > 0 ? q.size() - 1 : 0));
    chk("s_ready", 128'(s_ready), 128'(rst && q.size() <= D));
    chk("burst_done", 128'(burst_done), 128'(bd_m));
    chk("err_len", 128'(err_len), 128'(err_m));
    if (out_valid && q.size() > 0)
      chk("out_beat", 128'({out_id, out_data, out_resp, out_last, out_tagid}), 128'(q[0]));
    bd_m = 1'b0;
    if (rst) begin
      if (out_valid && out_ready && q.size() > 0) begin
        bd_m = q[0].last;
        void'(q.pop_front());
      end
      if (s_valid && s_ready) begin
        b = {s_id, s_data, s_resp, s_last, s_tagid};
        if (!s_last && cnt_m >= 256) err_m = 1'b1;
        cnt_m = s_last ? 0 : cnt_m + 1;
        q.push_back(b);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_beat(input logic [63:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_id    = 4'(d ^ 64'h9);
    s_resp  = 2'(d >> 2);
    s_tagid = 4'(d >> 3);
  endtask
  task automatic send(input logic [63:0] d, input logic l);
    set_beat(d, l);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_valid && s_ready) break;
      if (t == 200) begin
        checks++;
        $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
        break;
      end
    end
    cyc();
  endtask
  task automatic drain();
    s_valid   = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && out_valid; t++) cyc();
    chk("drained", 128'(out_valid), 128'(0));
  endtask
  task automatic random_run(input int n, input int pv, input int pr);
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!s_valid || acc) begin
        s_valid = $urandom_range(0, 99) < pv;
        s_data  = {$urandom, $urandom};
        s_id    = 4'($urandom);
        s_resp  = 2'($urandom);
        s_tagid = 4'($urandom);
        s_last  = $urandom_range(0, 99) < 25;
      end
      out_ready = $urandom_range(0, 99) < pr;
      @(negedge clk);
      acc = s_valid && s_ready;
      cyc();
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    out_ready = 1'b1;
    send(64'hA5, 1'b1);
    s_valid = 1'b0;
    chk("bypass_valid", 128'(out_valid), 128'(1));
    chk("bypass_data", 128'(out_data), 128'(64'hA5));
    chk("bypass_count", 128'(fifo_count), 128'(0));
    cyc();
    chk("bypass_done", 128'(burst_done), 128'(1));
    cyc();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(64'(i), 1'b0);
    chk("fill_count", 128'(fifo_count), 128'(4));
    set_beat(64'd6, 1'b1);
    cyc();
    cyc();
    chk("fill_stall", 128'(s_ready), 128'(0));
    chk("fill_hold", 128'(out_data), 128'(64'd1));
    out_ready = 1'b1;
    send(64'd6, 1'b1);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(64'(16 + i), 1'b0);
    chk("sim_count_pre", 128'(fifo_count), 128'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(64'(32 + i), i == 9);
    chk("sim_count_post", 128'(fifo_count), 128'(2));
    drain();
    for (int i = 1; i <= 257; i++) begin
      send(64'(256 + i), 1'b0);
      if (i == 256) chk("len_256", 128'(err_len), 128'(0));
    end
    chk("len_257", 128'(err_len), 128'(1));
    send(64'h777, 1'b1);
    chk("len_sticky", 128'(err_len), 128'(1));
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'(64 + i), 1'b0);
    chk("rst_pre_count", 128'(fifo_count), 128'(3));
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_count", 128'(fifo_count), 128'(0));
    chk("rst_ready", 128'(s_ready), 128'(0));
    chk("rst_err", 128'(err_len), 128'(0));
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rel_ready", 128'(s_ready), 128'(1));
    cyc();
    out_ready = 1'b1;
    send(64'h5A, 1'b1);
    s_valid = 1'b0;
    chk("rel_bypass", 128'(out_data), 128'(64'h5A));
    cyc();
    random_run(1500, 70, 20);
    random_run(1500, 60, 50);
    random_run(1500, 50, 90);
    drain();
    cyc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
